dp_cmp_writeback: RTL
=====================

// Module: dp_cmp_writeback
// PURPOSE
//  Sequential writeback stage directly downstream of the double-precision compare block (FEQ/FLT/FLE).
//  Captures the combinational compare result (flag_cmp, flag_invalid) with its destination register.
//  Buffers results in a 2-entry FIFO and presents them to the integer register file over a valid/ready handshake.
//  Accumulates the sticky NV exception bit of fflags from committed results.
// PARAMETERS
//  XLEN      64  width of integer writeback data; result is zero-extended to XLEN
//  RD_W      5   destination register index width
//  TAG_W     4   instruction tag width, carried through unchanged
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      compare result valid
//  in_ready     out  1      stage can accept a result
//  in_flag_cmp  in   1      compare outcome from compare block
//  in_flag_inv  in   1      invalid (SNaN) flag from compare block
//  in_rd        in   RD_W   destination integer register
//  in_tag       in   TAG_W  instruction tag
//  flush        in   1      discard all buffered results
//  wb_valid     out  1      writeback entry valid
//  wb_ready     in   1      register file accepts entry
//  wb_we        out  1      write enable = wb_valid && (wb_rd != 0)
//  wb_rd        out  RD_W   destination register of head entry
//  wb_data      out  XLEN   {XLEN-1 zeros, flag_cmp}
//  wb_tag       out  TAG_W  tag of head entry
//  fflags_clr   in   1      clear sticky NV
//  fflags_nv    out  1      sticky invalid-operation flag
// BEHAVIOUR
//  - Reset: FIFO empty, count=0; in_ready=1, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, wb_tag=0, fflags_nv=0.
//  - Push = in_valid && in_ready. Pop = wb_valid && wb_ready.
//  - in_ready = (count != 2), derived from registered count only; no combinational path from wb_ready.
//  - Latency: a result accepted in cycle N is visible on wb_* in cycle N+1 when the FIFO was empty. No bypass.
//  - Order: strict FIFO; wb_* always reflects the head entry.
//  - wb_* holds stable while wb_valid=1 and wb_ready=0.
//  - Count update: push only +1; pop only -1; push+pop: unchanged, head advances, new entry at tail.
//  - Full (count=2): in_ready=0, so no push occurs. Pop in the same cycle frees a slot; in_ready=1 next cycle.
//  - Empty: wb_valid=0 and wb_ready is ignored.
//  - Pointers are 1 bit each and wrap 1->0.
//  - flush: next cycle count=0; any same-cycle push is dropped; any same-cycle pop is not committed; fflags_nv is unaffected.
//  - fflags_nv: next = (fflags_clr ? 0 : fflags_nv) | (pop && head.inv).
//  - NV is set on commit (pop), never on accept. Clear and set in the same cycle leaves NV=1.
//  - wb_data[0] = head.cmp; wb_data[XLEN-1:1] = 0. rd=0 entries still pop, with wb_we=0.
//  - Reset mid-operation: all state returns to reset values immediately (async). Entries are lost.
// CONFIGURATION
//  - Macro DP_CMP_WB_PERF_EN, when defined, adds outputs perf_commits[31:0] and perf_invalids[31:0].
//    perf_commits increments on each pop; perf_invalids increments on each pop with inv=1.
//    Both counters wrap at 2^32-1 -> 0, reset to 0, and are not affected by flush.
//  - Without the macro: the ports and counters do not exist, and behaviour is otherwise identical.
// STRUCTURE
//  - Shared package fpu_pkg provides:
//    XLEN, RD_W, TAG_W defaults;
//    fflags bit indices (NV=4, DZ=3, OF=2, UF=1, NX=0);
//    compare func3 codes FLE=3'b000, FLT=3'b001, FEQ=3'b010;
//    typedef cmp_wb_entry_t {cmp, inv, rd, tag}.
//  - Sub-module dp_cmp_wb_fifo: generic 2-entry FIFO of cmp_wb_entry_t with count, pointers and flush.
//    The top level adds the handshake, wb_we/wb_data formatting, NV accumulation and perf counters.
// TESTING
//  - Reset/idle: rst_n=0 then 1 -> in_ready=1, wb_valid=0, fflags_nv=0.
//  - Single result: push cmp=1, inv=0, rd=5, tag=3 with wb_ready=1.
//    -> next cycle: wb_valid=1, wb_data=64'h1, wb_rd=5, wb_we=1, wb_tag=3.
//    -> following cycle: wb_valid=0.
//  - Backpressure/full: wb_ready=0; push tags 1, 2, 3 back-to-back.
//    -> tags 1 and 2 accepted, in_ready=0 at tag 3, wb_tag holds 1.
//    -> raise wb_ready: output order 1, 2, then tag 3 is accepted.
//  - Sticky NV: commit inv=1 -> fflags_nv=1; commit inv=0 -> stays 1.
//    fflags_clr alone -> 0; fflags_clr in the same cycle as an inv=1 pop -> 1.
//  - Flush: buffer 2 entries with inv=1, assert flush with wb_ready=1 and in_valid=1.
//    -> next cycle wb_valid=0, count=0, fflags_nv unchanged, pushed entry absent.
//  - x0 / async reset: an rd=0 entry pops with wb_we=0.
//    Asserting rst_n=0 mid-burst clears wb_valid without waiting for a clock edge.
//    With DP_CMP_WB_PERF_EN, perf_commits counts the rd=0 pop.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants, fflags indices, compare codes and compare-writeback entry type
package fpu_pkg;

    localparam int XLEN  = 64;
    localparam int RD_W  = 5;
    localparam int TAG_W = 4;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    localparam logic [2:0] FUNC3_FLE = 3'b000;
    localparam logic [2:0] FUNC3_FLT = 3'b001;
    localparam logic [2:0] FUNC3_FEQ = 3'b010;

    typedef struct packed {
        logic             cmp;
        logic             inv;
        logic [RD_W-1:0]  rd;
        logic [TAG_W-1:0] tag;
    } cmp_wb_entry_t;

endpackage

// File: rtl/dp_cmp_writeback_if.sv
// rtl/dp_cmp_writeback_if.sv - compare-result input and register-file writeback handshake bundle
interface dp_cmp_writeback_if #(
    parameter int XLEN  = 64,
    parameter int RD_W  = 5,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_flag_cmp;
    logic             in_flag_inv;
    logic [RD_W-1:0]  in_rd;
    logic [TAG_W-1:0] in_tag;

    logic             wb_valid;
    logic             wb_ready;
    logic             wb_we;
    logic [RD_W-1:0]  wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic [TAG_W-1:0] wb_tag;

    modport master (
        output in_valid, in_flag_cmp, in_flag_inv, in_rd, in_tag, wb_ready,
        input  in_ready, wb_valid, wb_we, wb_rd, wb_data, wb_tag
    );

    modport slave (
        input  in_valid, in_flag_cmp, in_flag_inv, in_rd, in_tag, wb_ready,
        output in_ready, wb_valid, wb_we, wb_rd, wb_data, wb_tag
    );
endinterface

// File: rtl/dp_cmp_wb_fifo.sv
// rtl/dp_cmp_wb_fifo.sv - two-entry FIFO with 1-bit pointers, occupancy count and synchronous flush
module dp_cmp_wb_fifo
    import fpu_pkg::*;
#(
    parameter type entry_t = cmp_wb_entry_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  entry_t     wdata,
    output entry_t     rdata,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);
    entry_t mem [2];
    logic   wr_ptr;
    logic   rd_ptr;
    logic   do_push;
    logic   do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/dp_cmp_writeback.sv
// rtl/dp_cmp_writeback.sv - compare-result writeback stage with sticky NV; DP_CMP_WB_PERF_EN adds commit counters
module dp_cmp_writeback
    import fpu_pkg::*;
#(
    parameter int XLEN  = fpu_pkg::XLEN,
    parameter int RD_W  = fpu_pkg::RD_W,
    parameter int TAG_W = fpu_pkg::TAG_W
) (
    input  logic                clk,
    input  logic                rst_n,
    dp_cmp_writeback_if.slave   bus,
    input  logic                flush,
    input  logic                fflags_clr,
    output logic                fflags_nv
`ifdef DP_CMP_WB_PERF_EN
    ,
    output logic [31:0]         perf_commits,
    output logic [31:0]         perf_invalids
`endif
);
    // Buffered entries use the shared entry type, so its field widths must match.
    if (RD_W != fpu_pkg::RD_W || TAG_W != fpu_pkg::TAG_W) begin : g_width_check
        $error("dp_cmp_writeback: RD_W/TAG_W must match fpu_pkg");
    end

    cmp_wb_entry_t in_entry;
    cmp_wb_entry_t head;
    logic [1:0]    count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          commit;

    assign in_entry = '{cmp: bus.in_flag_cmp, inv: bus.in_flag_inv,
                        rd: bus.in_rd, tag: bus.in_tag};

    // in_ready comes from registered occupancy only, never from wb_ready.
    assign bus.in_ready = !full;
    assign bus.wb_valid = !empty;
    assign push         = bus.in_valid && !full;
    assign pop          = !empty && bus.wb_ready;
    assign commit       = pop && !flush;

    dp_cmp_wb_fifo #(
        .entry_t (cmp_wb_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (in_entry),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign bus.wb_rd   = empty ? '0 : head.rd;
    assign bus.wb_tag  = empty ? '0 : head.tag;
    assign bus.wb_data = {{(XLEN-1){1'b0}}, (!empty && head.cmp)};
    assign bus.wb_we   = !empty && (head.rd != '0);

    // NV is raised on commit; a same-cycle clear cannot mask a new invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags_nv <= 1'b0;
        end else begin
            fflags_nv <= (fflags_clr ? 1'b0 : fflags_nv) | (commit && head.inv);
        end
    end

`ifdef DP_CMP_WB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_commits  <= 32'd0;
            perf_invalids <= 32'd0;
        end else if (commit) begin
            perf_commits <= perf_commits + 32'd1;
            if (head.inv) begin
                perf_invalids <= perf_invalids + 32'd1;
            end
        end
    end
`endif
endmodule
